ex_mem_reg: RTL and testbench

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/ex_mem_reg.sv | 139 +++++++++++++
 tb/tb_ex_mem_reg.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall, flush-to-bubble and a sticky HALTED state.
// Optional overflow trapping on ADD/SUB is enabled by defining OVF_TRAP_EN.
module ex_mem_reg (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ex_en,
  input  logic        flush,
  input  logic [31:0] alu_out_i,
  input  logic        zero_i,
  input  logic        negative_i,
  input  logic        overflow_i,
  input  logic [3:0]  aluop_i,
  input  logic [31:0] rdat2_i,
  input  logic [31:0] npc_i,
  input  logic [4:0]  wsel_i,
  input  logic        regwen_i,
  input  logic        dren_i,
  input  logic        dwen_i,
  input  logic        memtoreg_i,
  input  logic        halt_i,
  input  logic        valid_i,
  output logic [31:0] alu_out_o,
  output logic        zero_o,
  output logic        negative_o,
  output logic [31:0] rdat2_o,
  output logic [31:0] npc_o,
  output logic [4:0]  wsel_o,
  output logic        regwen_o,
  output logic        dren_o,
  output logic        dwen_o,
  output logic        memtoreg_o,
  output logic        halt_o,
`ifdef OVF_TRAP_EN
  output logic        ovf_exc_o,
`endif
  output logic        valid_o
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned SEL_W   = 5;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

  typedef struct packed {
    logic [WORD_W-1:0] alu_out;
    logic              zero;
    logic              negative;
    logic [WORD_W-1:0] rdat2;
    logic [WORD_W-1:0] npc;
    logic [SEL_W-1:0]  wsel;
    logic              regwen;
    logic              dren;
    logic              dwen;
    logic              memtoreg;
    logic              halt;
    logic              valid;
`ifdef OVF_TRAP_EN
    logic              ovf_exc;
`endif
  } ex_mem_t;

  state_e  state_q, state_d;
  ex_mem_t pipe_q, pipe_d;
  logic    capture_c;
  logic    trap_c;

  // A capture happens only while running, not flushed and not stalled.
  assign capture_c = (state_q == RUN) && !flush && ex_en;

`ifdef OVF_TRAP_EN
  localparam int unsigned ALUOP_W = 4;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd3;
  assign trap_c = valid_i && overflow_i && ((aluop_i == ALU_ADD) || (aluop_i == ALU_SUB));
`else
  logic unused_ovf;
  assign trap_c     = 1'b0;
  assign unused_ovf = ^{overflow_i, aluop_i};
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_d;
    end
  end

  // Only a valid halting entry parks the stage; reset is the sole exit.
  always_comb begin
    state_d = state_q;
    if (capture_c && valid_i && halt_i) begin
      state_d = HALTED;
    end
  end

  always_comb begin
    pipe_d = pipe_q;
    if ((state_q == RUN) && flush) begin
      pipe_d = '0;
    end else if (capture_c) begin
      pipe_d.alu_out  = alu_out_i;
      pipe_d.zero     = zero_i;
      pipe_d.negative = negative_i;
      pipe_d.rdat2    = rdat2_i;
      pipe_d.npc      = npc_i;
      pipe_d.wsel     = wsel_i;
      pipe_d.memtoreg = memtoreg_i;
      pipe_d.valid    = valid_i;
      pipe_d.halt     = valid_i & halt_i;
      // Invalid or trapped entries must not write; store beats load.
      pipe_d.regwen   = valid_i & regwen_i & ~trap_c;
      pipe_d.dwen     = valid_i & dwen_i & ~trap_c;
      pipe_d.dren     = valid_i & dren_i & ~dwen_i & ~trap_c;
`ifdef OVF_TRAP_EN
      pipe_d.ovf_exc  = trap_c;
`endif
    end
  end

  assign alu_out_o  = pipe_q.alu_out;
  assign zero_o     = pipe_q.zero;
  assign negative_o = pipe_q.negative;
  assign rdat2_o    = pipe_q.rdat2;
  assign npc_o      = pipe_q.npc;
  assign wsel_o     = pipe_q.wsel;
  assign regwen_o   = pipe_q.regwen;
  assign dren_o     = pipe_q.dren;
  assign dwen_o     = pipe_q.dwen;
  assign memtoreg_o = pipe_q.memtoreg;
  assign halt_o     = pipe_q.halt;
  assign valid_o    = pipe_q.valid;
`ifdef OVF_TRAP_EN
  assign ovf_exc_o  = pipe_q.ovf_exc;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: reference model compared every falling edge
// plus directed literal checks.
module tb_ex_mem_reg;

  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd4;

  logic        CLK, nRST, ex_en, flush;
  logic [31:0] alu_out_i, rdat2_i, npc_i;
  logic        zero_i, negative_i, overflow_i;
  logic [3:0]  aluop_i;
  logic [4:0]  wsel_i;
  logic        regwen_i, dren_i, dwen_i, memtoreg_i, halt_i, valid_i;
  logic [31:0] alu_out_o, rdat2_o, npc_o;
  logic        zero_o, negative_o;
  logic [4:0]  wsel_o;
  logic        regwen_o, dren_o, dwen_o, memtoreg_o, halt_o, valid_o;
`ifdef OVF_TRAP_EN
  logic        ovf_exc_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  ex_mem_reg dut (
    .CLK(CLK), .nRST(nRST), .ex_en(ex_en), .flush(flush),
    .alu_out_i(alu_out_i), .zero_i(zero_i), .negative_i(negative_i),
    .overflow_i(overflow_i), .aluop_i(aluop_i), .rdat2_i(rdat2_i), .npc_i(npc_i),
    .wsel_i(wsel_i), .regwen_i(regwen_i), .dren_i(dren_i), .dwen_i(dwen_i),
    .memtoreg_i(memtoreg_i), .halt_i(halt_i), .valid_i(valid_i),
    .alu_out_o(alu_out_o), .zero_o(zero_o), .negative_o(negative_o),
    .rdat2_o(rdat2_o), .npc_o(npc_o), .wsel_o(wsel_o), .regwen_o(regwen_o),
    .dren_o(dren_o), .dwen_o(dwen_o), .memtoreg_o(memtoreg_o), .halt_o(halt_o),
`ifdef OVF_TRAP_EN
    .ovf_exc_o(ovf_exc_o),
`endif
    .valid_o(valid_o)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model: expected output word and whether the stage has halted.
  logic [108:0] m_out;
  logic         m_halted;
  logic         m_ovf;
  wire  [108:0] dut_vec = {alu_out_o, zero_o, negative_o, rdat2_o, npc_o, wsel_o,
                           regwen_o, dren_o, dwen_o, memtoreg_o, halt_o, valid_o};

  function automatic logic model_trap();
`ifdef OVF_TRAP_EN
    return valid_i && overflow_i && (aluop_i == ALU_ADD || aluop_i == 4'd3);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [108:0] model_capture();
    logic t;
    logic we, rd, wr;
    t  = model_trap();
    we = valid_i && regwen_i && !t;
    wr = valid_i && dwen_i && !t;
    rd = valid_i && dren_i && !dwen_i && !t;
    return {alu_out_i, zero_i, negative_i, rdat2_i, npc_i, wsel_i,
            we, rd, wr, memtoreg_i, valid_i && halt_i, valid_i};
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_out    <= '0;
      m_ovf    <= 1'b0;
      m_halted <= 1'b0;
    end else if (!m_halted) begin
      if (flush) begin
        m_out <= '0;
        m_ovf <= 1'b0;
      end else if (ex_en) begin
        m_out <= model_capture();
        m_ovf <= model_trap();
        if (valid_i && halt_i) m_halted <= 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    n_cmp++;
    if (dut_vec !== m_out) begin
      n_bad++;
      $display("FAIL model_cmp t=%0t dut=%h exp=%h", $time, dut_vec, m_out);
    end
`ifdef OVF_TRAP_EN
    n_cmp++;
    if (ovf_exc_o !== m_ovf) begin
      n_bad++;
      $display("FAIL model_ovf t=%0t dut=%b exp=%b", $time, ovf_exc_o, m_ovf);
    end
`endif
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ex_en = 1'b1; flush = 1'b0;
    alu_out_i = '0; rdat2_i = '0; npc_i = '0; wsel_i = '0;
    zero_i = 1'b0; negative_i = 1'b0; overflow_i = 1'b0; aluop_i = '0;
    regwen_i = 1'b0; dren_i = 1'b0; dwen_i = 1'b0; memtoreg_i = 1'b0;
    halt_i = 1'b0; valid_i = 1'b0;
  endtask

  initial begin
    // Reset held while every input is busy.
    nRST = 1'b0;
    ex_en = 1'b1; flush = 1'b0;
    alu_out_i = 32'hFFFF_FFFF; rdat2_i = 32'h1111_1111; npc_i = 32'h0000_0004;
    wsel_i = 5'd31; zero_i = 1'b1; negative_i = 1'b1; overflow_i = 1'b1;
    aluop_i = ALU_ADD; regwen_i = 1'b1; dren_i = 1'b1; dwen_i = 1'b1;
    memtoreg_i = 1'b1; halt_i = 1'b1; valid_i = 1'b1;
    step(2);
    chk("rst_alu", alu_out_o, 32'h0);
    chk("rst_ctrl", 32'({regwen_o, dren_o, dwen_o, memtoreg_o, halt_o, valid_o}), 32'h0);

    // First capture after release.
    clear_inputs();
    alu_out_i = 32'h0000_1234; wsel_i = 5'd5; regwen_i = 1'b1; valid_i = 1'b1;
    nRST = 1'b1;
    step(1);
    chk("cap_alu", alu_out_o, 32'h0000_1234);
    chk("cap_wsel", 32'(wsel_o), 32'd5);
    chk("cap_regwen", 32'(regwen_o), 32'd1);

    // Stall holds the captured word.
    alu_out_i = 32'hAAAA_AAAA;
    step(1);
    chk("pre_stall", alu_out_o, 32'hAAAA_AAAA);
    ex_en = 1'b0; alu_out_i = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_hold", alu_out_o, 32'hAAAA_AAAA);
    end
    ex_en = 1'b1;
    step(1);
    chk("stall_release", alu_out_o, 32'h5555_5555);

    // Flush wins over stall.
    flush = 1'b1; ex_en = 1'b0; regwen_i = 1'b1; dwen_i = 1'b1;
    step(1);
    chk("flush_bubble", 32'({valid_o, regwen_o, dwen_o}), 32'h0);
    chk("flush_alu", alu_out_o, 32'h0);

    // Invalid entry carries no side effects and does not halt.
    clear_inputs();
    valid_i = 1'b0; regwen_i = 1'b1; dwen_i = 1'b1; halt_i = 1'b1; alu_out_i = 32'h0BAD_0001;
    step(1);
    chk("inv_ctrl", 32'({regwen_o, dwen_o, valid_o, halt_o}), 32'h0);
    chk("inv_alu", alu_out_o, 32'h0BAD_0001);

    // Store beats load.
    clear_inputs();
    valid_i = 1'b1; dren_i = 1'b1; dwen_i = 1'b1;
    step(1);
    chk("rw_excl", 32'({dren_o, dwen_o}), 32'h1);

    // Overflow handling on ADD vs AND.
    clear_inputs();
    valid_i = 1'b1; regwen_i = 1'b1; overflow_i = 1'b1;
    aluop_i = ALU_ADD; alu_out_i = 32'h8000_0000;
    step(1);
    chk("ovf_add_alu", alu_out_o, 32'h8000_0000);
`ifdef OVF_TRAP_EN
    chk("ovf_add_exc", 32'(ovf_exc_o), 32'd1);
    chk("ovf_add_regwen", 32'(regwen_o), 32'd0);
`else
    chk("ovf_add_regwen", 32'(regwen_o), 32'd1);
`endif
    aluop_i = ALU_AND;
    step(1);
`ifdef OVF_TRAP_EN
    chk("ovf_and_exc", 32'(ovf_exc_o), 32'd0);
`endif
    chk("ovf_and_regwen", 32'(regwen_o), 32'd1);

    // Mixed traffic, no halts; the model tracks every cycle.
    for (int i = 0; i < 20; i++) begin
      alu_out_i = $urandom; rdat2_i = $urandom; npc_i = $urandom;
      wsel_i = 5'($urandom); aluop_i = 4'($urandom_range(0, 9));
      {zero_i, negative_i, overflow_i, regwen_i, dren_i, dwen_i, memtoreg_i, valid_i} = 8'($urandom);
      halt_i = 1'b0;
      ex_en = ($urandom_range(0, 3) != 0);
      flush = (i % 5 == 4);
      step(1);
    end

    // Reset in the middle of a stall.
    clear_inputs();
    valid_i = 1'b1; alu_out_i = 32'hCAFE_0000; regwen_i = 1'b1;
    step(1);
    ex_en = 1'b0;
    step(1);
    #2 nRST = 1'b0;
    #1 chk("stall_rst_alu", alu_out_o, 32'h0);
    step(1);
    nRST = 1'b1; ex_en = 1'b1; alu_out_i = 32'hCAFE_0001;
    step(1);
    chk("post_rst_cap", alu_out_o, 32'hCAFE_0001);

    // Halt is sticky against flush and new inputs until reset.
    clear_inputs();
    valid_i = 1'b1; halt_i = 1'b1; alu_out_i = 32'hDEAD_BEEF;
    step(1);
    chk("halt_set", 32'(halt_o), 32'd1);
    halt_i = 1'b0; flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_out_i = 32'(i + 1); flush = i[0];
      step(1);
      chk("halted_alu", alu_out_o, 32'hDEAD_BEEF);
      chk("halted_halt", 32'(halt_o), 32'd1);
    end
    nRST = 1'b0;
    #1 chk("halt_rst", 32'(halt_o), 32'd0);
    step(1);
    nRST = 1'b1;
    clear_inputs();
    valid_i = 1'b1; alu_out_i = 32'h0000_0077;
    step(1);
    chk("rerun_cap", alu_out_o, 32'h0000_0077);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
